ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of the ALU result and store data.
REQ-002 Parameter: RADDR_W, 5, register-file address width.
REQ-003 Port: clk  in  1  single clock; all state on its rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  in  1  execute stage presents an instruction.
REQ-006 Port: in_ready  out  1  stage can accept this cycle.
REQ-007 Port: alu_out  in  DATA_W  ALU result (address for loads/stores).
REQ-008 Port: rs2_data  in  DATA_W  store source data.
REQ-009 Port: mem_op  in  4  memory op code (package enum).
REQ-010 Port: rd / reg_we  in  RADDR_W / 1  destination register and write-enable.
REQ-011 Port: flush  in  1  kill the held entry and the incoming one.
REQ-012 Port: out_ready  in  1  memory/writeback side accepts.
REQ-013 Port: out_valid  out  1  entry held.
REQ-014 Port: mem_addr  out  DATA_W  {result[31:2],2'b00}.
REQ-015 Port: mem_wdata / mem_wbe / mem_re  out  DATA_W / 4 / 1  store data, byte enables, load strobe.
REQ-016 Port: rd_out / reg_we_out / result_out / op_out / byte_off  out  RADDR_W / 1 / DATA_W / 4 / 2  to writeback.
REQ-017 Port: fwd_valid / fwd_data / load_hazard  out  1 / DATA_W / 1  forwarding to execute.
REQ-018 Port: misalign / misalign_cnt  out  1 / 8  registered fault flag, saturating fault count.

Function
REQ-019 Stage holds exactly one entry; in_ready = !valid_q | out_ready (combinational, no flush dependence).
REQ-020 Capture on in_valid & in_ready & !flush; valid_q <= 1 and all fields register same edge (latency 1).
REQ-021 Release on valid_q & out_ready with no capture: valid_q <= 0; simultaneous release+capture keeps valid_q = 1 with new fields.
REQ-022 flush: valid_q <= 0 next edge, overrides capture; misalign_cnt unchanged by flushed ops.
REQ-023 SB: wbe = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}; SH: wbe = 4'b0011 << {addr[1],0}, wdata = {2{rs2[15:0]}}; SW: wbe = 4'b1111, wdata = rs2.
REQ-024 Misaligned: halfword ops with addr[0]=1, word ops with addr[1:0]!=0; computed at capture, stored in misalign_q.
REQ-025 Misaligned entry: wbe = 0, mem_re = 0, reg_we_out = 0, misalign = 1 while held.
REQ-026 mem_wbe and mem_re asserted only when valid_q & out_ready (one side effect per entry); all are 0 otherwise.
REQ-027 misalign_cnt increments once per captured misaligned entry, saturates at 255.
REQ-028 fwd_valid = valid_q & reg_we_q & rd_q != 0 & op is not a load & !misalign_q; fwd_data = result_q.
REQ-029 load_hazard = valid_q & reg_we_q & rd_q != 0 & op is a load.
REQ-030 byte_off = result_q[1:0] for writeback load extraction.

Reset
REQ-031 rst_n low: valid_q, misalign_q, misalign_cnt, all outputs forced 0 immediately, independent of clk.
REQ-032 Reset mid-transfer discards the held entry; first capture allowed on the first edge after rst_n rises.

Structure
REQ-033 Shared package: mem_op enum (NONE, LB, LH, LW, LBU, LHU, SB, SH, SW), is_load/is_store helpers, DATA_W default.
REQ-034 One sub-module, store_align: combinational wbe/wdata/misalign from op, addr[1:0], rs2.

Verification
REQ-035 SB alu_out=0x1003, rs2=0xAB -> next cycle wbe=4'b1000, wdata=0xABABABAB, mem_addr=0x1000.
REQ-036 LW alu_out=0x2002 -> misalign=1, mem_re=0, reg_we_out=0, misalign_cnt 0->1.
REQ-037 ADD rd=5 result=0x7 held with out_ready=0 -> in_ready=0, fwd_valid=1, fwd_data=0x7, outputs stable until out_ready=1.
REQ-038 Held entry + in_valid + out_ready + flush same cycle -> out_valid=0 next cycle, no wbe pulse after flush.
REQ-039 rst_n low mid-SW with out_ready=0 -> out_valid, wbe, misalign_cnt =0 before next clk edge.
REQ-040 300 misaligned SH captures -> misalign_cnt = 255, no wrap.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the execute/memory pipeline boundary: memory op codes and
// load/store classification helpers.
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    function automatic logic is_load(mem_op_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/ex_mem_stage_store_align.sv
// Combinational store lane steering: byte enables, replicated write data and
// the alignment fault for the op presented by the execute stage.
module store_align
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rs2,
    output logic [3:0]        wbe,
    output logic [DATA_W-1:0] wdata,
    output logic              misalign
);

    mem_op_e op_e;
    assign op_e = mem_op_e'(op);

    always_comb begin
        wbe      = 4'b0000;
        wdata    = '0;
        misalign = 1'b0;
        case (op_e)
            OP_LH, OP_LHU: misalign = addr_lo[0];
            OP_LW:         misalign = |addr_lo;
            OP_SB: begin
                wbe   = 4'b0001 << addr_lo;
                wdata = {(DATA_W/8){rs2[7:0]}};
            end
            OP_SH: begin
                misalign = addr_lo[0];
                wbe      = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {(DATA_W/16){rs2[15:0]}};
            end
            OP_SW: begin
                misalign = |addr_lo;
                wbe      = 4'b1111;
                wdata    = rs2;
            end
            default: ;
        endcase
        // A faulting access must never touch memory.
        if (misalign)
            wbe = 4'b0000;
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Single-entry EX/MEM pipeline register with store alignment, load strobe,
// forwarding/hazard outputs and a saturating misalignment counter.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [DATA_W-1:0]  rs2_data,
    input  logic [3:0]         mem_op,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_we,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [3:0]         mem_wbe,
    output logic               mem_re,
    output logic [RADDR_W-1:0] rd_out,
    output logic               reg_we_out,
    output logic [DATA_W-1:0]  result_out,
    output logic [3:0]         op_out,
    output logic [1:0]         byte_off,
    output logic               fwd_valid,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               load_hazard,
    output logic               misalign,
    output logic [7:0]         misalign_cnt
);

    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [3:0]        sa_wbe;
    logic [DATA_W-1:0] sa_wdata;
    logic              sa_mis;

    store_align #(.DATA_W(DATA_W)) u_store_align (
        .op       (mem_op),
        .addr_lo  (alu_out[1:0]),
        .rs2      (rs2_data),
        .wbe      (sa_wbe),
        .wdata    (sa_wdata),
        .misalign (sa_mis)
    );

    logic               vld_p1;
    logic               misalign_p1;
    logic [7:0]         cnt_p1;
    logic [DATA_W-1:0]  result_p1;
    logic [DATA_W-1:0]  wdata_p1;
    logic [3:0]         wbe_p1;
    mem_op_e            op_p1;
    logic [RADDR_W-1:0] rd_p1;
    logic               reg_we_p1;
    logic               capture;
    logic               fire;

    assign in_ready = rst_n & (!vld_p1 | out_ready);
    assign capture  = in_valid & in_ready & !flush;
    // A flushed entry is dead this cycle too, so it must not fire its side effect.
    assign fire     = vld_p1 & out_ready & !flush;

    // ---- EX -> MEM boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            misalign_p1 <= 1'b0;
            cnt_p1      <= 8'd0;
            result_p1   <= '0;
            wdata_p1    <= '0;
            wbe_p1      <= 4'b0000;
            op_p1       <= OP_NONE;
            rd_p1       <= '0;
            reg_we_p1   <= 1'b0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (capture)
                vld_p1 <= 1'b1;
            else if (vld_p1 && out_ready)
                vld_p1 <= 1'b0;

            if (capture) begin
                misalign_p1 <= sa_mis;
                result_p1   <= alu_out;
                wdata_p1    <= sa_wdata;
                wbe_p1      <= sa_wbe;
                op_p1       <= mem_op_e'(mem_op);
                rd_p1       <= rd;
                reg_we_p1   <= reg_we;
                if (sa_mis)
                    cnt_p1 <= sat_inc8(cnt_p1);
            end
        end
    end

    assign out_valid    = vld_p1;
    assign mem_addr     = {result_p1[DATA_W-1:2], 2'b00};
    assign mem_wdata    = wdata_p1;
    assign mem_wbe      = fire ? wbe_p1 : 4'b0000;
    assign mem_re       = fire & is_load(op_p1) & !misalign_p1;
    assign rd_out       = rd_p1;
    assign reg_we_out   = vld_p1 & reg_we_p1 & !misalign_p1;
    assign result_out   = result_p1;
    assign op_out       = op_p1;
    assign byte_off     = result_p1[1:0];
    assign fwd_valid    = vld_p1 & reg_we_p1 & (rd_p1 != '0) & !is_load(op_p1) & !misalign_p1;
    assign fwd_data     = result_p1;
    assign load_hazard  = vld_p1 & reg_we_p1 & (rd_p1 != '0) & is_load(op_p1);
    assign misalign     = vld_p1 & misalign_p1;
    assign misalign_cnt = cnt_p1;

endmodule
